// File: rtl/fetch_mw_ibuf_if.sv
// Fetch unit bus bundle: warp control, redirect, instruction memory and
// decode-side handshakes. The fetch unit is the master of this bundle.
interface fetch_mw_ibuf_if #(
    parameter int NUM_WARPS  = 8,
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    localparam int WID_W = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0]  warp_active;
    logic                  pc_set_valid;
    logic [WID_W-1:0]      pc_set_warp;
    logic [PC_WIDTH-1:0]   pc_set_pc;
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [PC_WIDTH-1:0]   imem_req_addr;
    logic [WID_W-1:0]      imem_req_tag;
    logic                  imem_rsp_valid;
    logic [INST_WIDTH-1:0] imem_rsp_data;
    logic [WID_W-1:0]      imem_rsp_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_WIDTH-1:0] out_inst;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [WID_W-1:0]      out_warp;

    modport master (
        input  warp_active, pc_set_valid, pc_set_warp, pc_set_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_tag,
        input  out_ready,
        output imem_req_valid, imem_req_addr, imem_req_tag,
        output out_valid, out_inst, out_pc, out_warp
    );

    modport slave (
        output warp_active, pc_set_valid, pc_set_warp, pc_set_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_tag,
        output out_ready,
        input  imem_req_valid, imem_req_addr, imem_req_tag,
        input  out_valid, out_inst, out_pc, out_warp
    );
endinterface

// File: rtl/fetch_mw_ibuf.sv
// Multi-warp instruction fetch: per-warp PC and instruction buffer,
// round-robin request issue to instruction memory, round-robin delivery to
// decode, and PC redirect with flush/squash of stale fetches.
module fetch_mw_ibuf #(
    parameter int NUM_WARPS  = 8,
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int IBUF_DEPTH = 2,
    parameter int PC_STEP    = 4
) (
    input logic clk,
    input logic rst,
    fetch_mw_ibuf_if.master bus
);
    localparam int WID_W = $clog2(NUM_WARPS);
    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);
    localparam int PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    logic [PC_WIDTH-1:0]   pc       [NUM_WARPS];
    logic [PC_WIDTH-1:0]   req_pc   [NUM_WARPS];
    logic [CNT_W-1:0]      count    [NUM_WARPS];
    logic [PTR_W-1:0]      head     [NUM_WARPS];
    logic [INST_WIDTH-1:0] ib_inst  [NUM_WARPS][IBUF_DEPTH];
    logic [PC_WIDTH-1:0]   ib_pc    [NUM_WARPS][IBUF_DEPTH];
    logic [NUM_WARPS-1:0]  outstanding, discard;
    logic [WID_W-1:0]      rr_req, rr_out;

    // registered request; req_stale marks a pending request whose warp was
    // redirected before acceptance, so its response must be thrown away
    logic                  req_valid, req_stale;
    logic [PC_WIDTH-1:0]   req_addr;
    logic [WID_W-1:0]      req_tag;

    // hold keeps the presented warp fixed while decode back-pressures
    logic                  hold;
    logic [WID_W-1:0]      hold_warp;

    logic                  accept, pick_found, scan_found, out_valid;
    logic [WID_W-1:0]      req_start, pick_warp, scan_warp, sel;
    logic [NUM_WARPS-1:0]  set_hit, acc_hit, rsp_hit, elig, has_inst, push, pop;

    function automatic logic [WID_W-1:0] inc_warp(input logic [WID_W-1:0] w);
        if (int'(w) == NUM_WARPS - 1) return '0;
        return w + WID_W'(1);
    endfunction

    assign accept = req_valid && bus.imem_req_ready;

    // per-warp event decode and request eligibility
    always_comb begin
        set_hit  = '0;
        acc_hit  = '0;
        rsp_hit  = '0;
        elig     = '0;
        has_inst = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            set_hit[w]  = bus.pc_set_valid && (int'(bus.pc_set_warp) == w);
            acc_hit[w]  = accept && (int'(req_tag) == w);
            rsp_hit[w]  = bus.imem_rsp_valid && (int'(bus.imem_rsp_tag) == w) && outstanding[w];
            elig[w]     = bus.warp_active[w] && !outstanding[w] && !acc_hit[w] && !set_hit[w]
                          && (int'(count[w]) < IBUF_DEPTH);
            has_inst[w] = (count[w] != '0);
        end
    end

    // round-robin pick for the next request and for the decode output
    always_comb begin
        req_start  = accept ? inc_warp(req_tag) : rr_req;
        pick_found = 1'b0;
        pick_warp  = '0;
        scan_found = 1'b0;
        scan_warp  = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!pick_found && elig[WID_W'((int'(req_start) + i) % NUM_WARPS)]) begin
                pick_found = 1'b1;
                pick_warp  = WID_W'((int'(req_start) + i) % NUM_WARPS);
            end
            if (!scan_found && has_inst[WID_W'((int'(rr_out) + i) % NUM_WARPS)]) begin
                scan_found = 1'b1;
                scan_warp  = WID_W'((int'(rr_out) + i) % NUM_WARPS);
            end
        end
    end

    // output selection; a redirect of the presented warp withdraws it at once
    always_comb begin
        sel       = hold ? hold_warp : scan_warp;
        out_valid = has_inst[sel] && !set_hit[sel];
        push      = '0;
        pop       = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push[w] = rsp_hit[w] && !discard[w] && !set_hit[w];
            pop[w]  = out_valid && bus.out_ready && (int'(sel) == w);
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = req_addr;
    assign bus.imem_req_tag   = req_tag;
    assign bus.out_valid      = out_valid;
    assign bus.out_inst       = ib_inst[sel][head[sel]];
    assign bus.out_pc         = ib_pc[sel][head[sel]];
    assign bus.out_warp       = sel;

    // request register, arbiter pointers and output hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid <= 1'b0;
            req_stale <= 1'b0;
            req_addr  <= '0;
            req_tag   <= '0;
            rr_req    <= '0;
            rr_out    <= '0;
            hold      <= 1'b0;
            hold_warp <= '0;
        end else begin
            if (!req_valid || accept) begin
                req_valid <= pick_found;
                req_addr  <= pc[pick_warp];
                req_tag   <= pick_warp;
                req_stale <= 1'b0;
            end else if (set_hit[req_tag]) begin
                req_stale <= 1'b1;
            end
            if (accept) rr_req <= inc_warp(req_tag);
            hold      <= out_valid && !bus.out_ready;
            hold_warp <= sel;
            if (out_valid && bus.out_ready) rr_out <= inc_warp(sel);
        end
    end

    // per-warp PC, in-flight tracking and instruction buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc[w]     <= '0;
                req_pc[w] <= '0;
                count[w]  <= '0;
                head[w]   <= '0;
                for (int d = 0; d < IBUF_DEPTH; d++) begin
                    ib_inst[w][d] <= '0;
                    ib_pc[w][d]   <= '0;
                end
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (set_hit[w])
                    pc[w] <= bus.pc_set_pc;
                else if (acc_hit[w] && !req_stale)
                    pc[w] <= req_addr + PC_WIDTH'(PC_STEP);
                if (acc_hit[w]) req_pc[w] <= req_addr;

                if (acc_hit[w])
                    outstanding[w] <= 1'b1;
                else if (rsp_hit[w])
                    outstanding[w] <= 1'b0;

                if (set_hit[w] && ((outstanding[w] && !rsp_hit[w]) || acc_hit[w]))
                    discard[w] <= 1'b1;
                else if (acc_hit[w] && req_stale)
                    discard[w] <= 1'b1;
                else if (rsp_hit[w])
                    discard[w] <= 1'b0;

                if (push[w]) begin
                    ib_inst[w][PTR_W'((int'(head[w]) + int'(count[w])) % IBUF_DEPTH)] <= bus.imem_rsp_data;
                    ib_pc[w][PTR_W'((int'(head[w]) + int'(count[w])) % IBUF_DEPTH)]   <= req_pc[w];
                end
                if (pop[w])
                    head[w] <= (int'(head[w]) == IBUF_DEPTH - 1) ? '0 : head[w] + PTR_W'(1);

                if (set_hit[w])
                    count[w] <= '0;
                else if (push[w] && !pop[w])
                    count[w] <= count[w] + CNT_W'(1);
                else if (pop[w] && !push[w])
                    count[w] <= count[w] - CNT_W'(1);
            end
        end
    end

    // a response must belong to a warp with a fetch in flight
    assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid |-> outstanding[bus.imem_rsp_tag]);

endmodule

// File: tb/tb_fetch_mw_ibuf.sv
// Directed bench for fetch_mw_ibuf: launch, back-pressure, redirects,
// request stall, PC wrap and asynchronous reset.
module tb_fetch_mw_ibuf;
    localparam int NW  = 8;
    localparam int PCW = 32;
    localparam int IW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_mw_ibuf_if #(.NUM_WARPS(NW), .PC_WIDTH(PCW), .INST_WIDTH(IW)) bus ();

    fetch_mw_ibuf #(
        .NUM_WARPS(NW), .PC_WIDTH(PCW), .INST_WIDTH(IW), .IBUF_DEPTH(2), .PC_STEP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    bit mem_auto;

    logic [31:0] req_log[$];
    logic [31:0] out_pc_log[$];
    logic [31:0] out_inst_log[$];
    logic [2:0]  out_warp_log[$];

    logic [31:0] exp_launch[6] = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    logic [31:0] exp_bp[4]     = '{32'h300, 32'h500, 32'h304, 32'h504};
    logic [2:0]  exp_bp_w[4]   = '{3'd0, 3'd1, 3'd0, 3'd1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // one clock: log handshakes before the edge, then model a one-cycle memory
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic [2:0]  t;
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        t   = bus.imem_req_tag;
        if (acc) req_log.push_back(a);
        if (bus.out_valid && bus.out_ready) begin
            out_pc_log.push_back(bus.out_pc);
            out_inst_log.push_back(bus.out_inst);
            out_warp_log.push_back(bus.out_warp);
        end
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = acc && mem_auto;
        bus.imem_rsp_tag   = t;
        bus.imem_rsp_data  = inst_of(a);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        req_log.delete();
        out_pc_log.delete();
        out_inst_log.delete();
        out_warp_log.delete();
    endtask

    task automatic set_pc(input logic [2:0] w, input logic [31:0] p);
        bus.pc_set_valid = 1'b1;
        bus.pc_set_warp  = w;
        bus.pc_set_pc    = p;
        tick();
        bus.pc_set_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget);
        for (int i = 0; i < budget && req_log.size() < n; i++) tick();
    endtask

    task automatic drain();
        bus.warp_active    = '0;
        bus.out_ready      = 1'b1;
        bus.imem_req_ready = 1'b1;
        mem_auto           = 1'b1;
        run(12);
        clear_logs();
    endtask

    initial begin
        rst                = 1'b1;
        mem_auto           = 1'b1;
        bus.warp_active    = '0;
        bus.pc_set_valid   = 1'b0;
        bus.pc_set_warp    = '0;
        bus.pc_set_pc      = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_tag   = '0;
        bus.out_ready      = 1'b0;
        #12;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_inst", bus.out_inst, 0);
        chk("rst_out_warp", bus.out_warp, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // launch two warps, alternating fetch order
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        set_pc(3'd0, 32'h100);
        set_pc(3'd1, 32'h200);
        bus.warp_active = 8'h03;
        wait_reqs(6, 40);
        bus.warp_active = 8'h00;
        run(12);
        for (int i = 0; i < 6; i++) begin
            chk("launch_req", req_log[i], exp_launch[i]);
            chk("launch_out_pc", out_pc_log[i], exp_launch[i]);
            chk("launch_out_warp", out_warp_log[i], 64'(i % 2));
        end
        chk("launch_inst0", out_inst_log[0], inst_of(32'h100));
        chk("launch_inst3", out_inst_log[3], inst_of(32'h204));
        drain();

        // decode back-pressure: buffers fill, then requests stop
        set_pc(3'd0, 32'h300);
        set_pc(3'd1, 32'h500);
        bus.out_ready   = 1'b0;
        bus.warp_active = 8'h03;
        run(20);
        chk("bp_req_count", req_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_req", req_log[i], exp_bp[i]);
        chk("bp_req_valid", bus.imem_req_valid, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_out_pc", bus.out_pc, 32'h300);
        run(3);
        chk("bp_out_pc_stable", bus.out_pc, 32'h300);
        chk("bp_out_warp_stable", bus.out_warp, 0);
        bus.warp_active = 8'h00;
        bus.out_ready   = 1'b1;
        run(10);
        chk("bp_out_count", out_pc_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_pc", out_pc_log[i], exp_bp[i]);
            chk("bp_out_warp", out_warp_log[i], exp_bp_w[i]);
        end
        drain();

        // redirect while a fetch is in flight
        set_pc(3'd0, 32'h108);
        mem_auto        = 1'b0;
        bus.warp_active = 8'h01;
        wait_reqs(1, 10);
        chk("redir_req0", req_log[0], 32'h108);
        set_pc(3'd0, 32'h400);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_tag   = 3'd0;
        bus.imem_rsp_data  = inst_of(32'h108);
        tick();
        chk("redir_dropped", bus.out_valid, 0);
        mem_auto = 1'b1;
        run(10);
        chk("redir_req1", req_log[1], 32'h400);
        chk("redir_out_pc", out_pc_log[0], 32'h400);
        chk("redir_out_inst", out_inst_log[0], inst_of(32'h400));
        chk("redir_out_warp", out_warp_log[0], 0);
        chk("redir_out_pc1", out_pc_log[1], 32'h404);
        drain();

        // request stalled by memory, redirected while pending
        set_pc(3'd2, 32'h700);
        bus.imem_req_ready = 1'b0;
        bus.warp_active    = 8'h04;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.pc_set_valid = 1'b1;
                bus.pc_set_warp  = 3'd2;
                bus.pc_set_pc    = 32'h800;
            end
            tick();
            bus.pc_set_valid = 1'b0;
            chk("stall_valid", bus.imem_req_valid, 1);
            chk("stall_addr", bus.imem_req_addr, 32'h700);
            chk("stall_tag", bus.imem_req_tag, 2);
        end
        bus.imem_req_ready = 1'b1;
        run(10);
        chk("stall_req0", req_log[0], 32'h700);
        chk("stall_req1", req_log[1], 32'h800);
        chk("stall_out_pc", out_pc_log[0], 32'h800);
        chk("stall_out_warp", out_warp_log[0], 2);
        drain();

        // PC wraps past the top of the address space
        set_pc(3'd3, 32'hFFFF_FFFC);
        bus.warp_active = 8'h08;
        wait_reqs(2, 20);
        bus.warp_active = 8'h00;
        run(8);
        chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        chk("wrap_req1", req_log[1], 32'h0);
        chk("wrap_out_pc0", out_pc_log[0], 32'hFFFF_FFFC);
        chk("wrap_out_pc1", out_pc_log[1], 32'h0);
        drain();

        // asynchronous reset in the middle of activity
        set_pc(3'd0, 32'h900);
        bus.out_ready   = 1'b0;
        bus.warp_active = 8'h01;
        run(4);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        chk("pre_rst_req_valid", bus.imem_req_valid, 1);
        clear_logs();
        #2;
        rst                = 1'b1;
        mem_auto           = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.warp_active    = 8'h00;
        #1;
        chk("rst_mid_req_valid", bus.imem_req_valid, 0);
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_out_pc", bus.out_pc, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_auto           = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        run(6);
        chk("post_rst_reqs", req_log.size(), 0);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_req_valid", bus.imem_req_valid, 0);
        set_pc(3'd0, 32'hA00);
        bus.warp_active = 8'h01;
        wait_reqs(1, 10);
        chk("post_rst_first_req", req_log[0], 32'hA00);
        bus.warp_active = 8'h00;
        run(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
